// File: rtl/p4_arb_pkg.sv
// Shared types and sizing helpers for the P4 ingress arbiter.
package p4_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int unsigned PKT_CNT_W = 32;

  // Width of a port index; never below one bit so a 1-port build still elaborates.
  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/p4_ingress_arbiter_rr_prio_picker.sv
// rr_prio_picker: combinational round-robin picker returning the first
// requesting port strictly after last_grant, searching cyclically.
module rr_prio_picker
  import p4_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = arb_idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic                 any_req,
  output logic [IDX_W-1:0]     next_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    any_req  = |req;
    next_idx = '0;
    found    = 1'b0;
    cand     = '0;
    // Offsets 1..NUM_PORTS visit every port once, ending on last_grant itself.
    for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
      cand = IDX_W'((32'(last_grant) + off) % NUM_PORTS);
      if (!found && req[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

endmodule

// File: rtl/p4_ingress_arbiter.sv
// p4_ingress_arbiter: packet-atomic round-robin mux of NUM_PORTS AXI-Stream
// ingress ports onto one P4 pipeline input. Define P4_ARB_PKT_CNT_EN for pkt_cnt.
module p4_ingress_arbiter
  import p4_arb_pkg::*;
#(
  parameter int NUM_PORTS            = 4,
  parameter int TDATA_NUM_BYTES      = 64,
  parameter int USER_META_DATA_WIDTH = 9
) (
  input  logic                                   s_axis_aclk,
  input  logic                                   s_axis_aresetn,
  input  logic [NUM_PORTS*TDATA_NUM_BYTES*8-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*TDATA_NUM_BYTES-1:0]   s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]                   s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                   s_axis_tlast,
  output logic [NUM_PORTS-1:0]                   s_axis_tready,
  output logic [TDATA_NUM_BYTES*8-1:0]           m_axis_tdata,
  output logic [TDATA_NUM_BYTES-1:0]             m_axis_tkeep,
  output logic                                   m_axis_tvalid,
  output logic                                   m_axis_tlast,
  input  logic                                   m_axis_tready,
  output logic [USER_META_DATA_WIDTH-1:0]        user_metadata_out,
  output logic                                   user_metadata_out_valid
`ifdef P4_ARB_PKT_CNT_EN
  ,
  output logic [NUM_PORTS*PKT_CNT_W-1:0]         pkt_cnt
`endif
);

  localparam int IDX_W = arb_idx_w(NUM_PORTS);
  localparam int DW    = TDATA_NUM_BYTES * 8;
  localparam int KW    = TDATA_NUM_BYTES;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic             first_beat_q, first_beat_d;

  logic             any_req;
  logic [IDX_W-1:0] next_idx;
  logic             xfer;
  logic             beat_hs;
  logic             pkt_done;

  logic [DW-1:0]    port_tdata [NUM_PORTS];
  logic [KW-1:0]    port_tkeep [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign port_tdata[g] = s_axis_tdata[g*DW +: DW];
    assign port_tkeep[g] = s_axis_tkeep[g*KW +: KW];
  end

  rr_prio_picker #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (IDX_W)
  ) u_picker (
    .req       (s_axis_tvalid),
    .last_grant(last_grant_q),
    .any_req   (any_req),
    .next_idx  (next_idx)
  );

  // Data path is a pure mux of the granted port, forced to zero outside XFER
  // so an asynchronous reset clears every output without waiting for a clock.
  always_comb begin
    xfer           = (state_q == XFER);
    m_axis_tvalid  = xfer & s_axis_tvalid[grant_idx_q];
    m_axis_tlast   = xfer & s_axis_tlast[grant_idx_q];
    m_axis_tdata   = xfer ? port_tdata[grant_idx_q] : '0;
    m_axis_tkeep   = xfer ? port_tkeep[grant_idx_q] : '0;
    s_axis_tready  = '0;
    if (xfer) begin
      s_axis_tready[grant_idx_q] = m_axis_tready;
    end
    beat_hs                 = m_axis_tvalid & m_axis_tready;
    pkt_done                = beat_hs & m_axis_tlast;
    user_metadata_out       = USER_META_DATA_WIDTH'(grant_idx_q);
    user_metadata_out_valid = m_axis_tvalid & first_beat_q;
  end

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    first_beat_d = first_beat_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = XFER;
          grant_idx_d  = next_idx;
          first_beat_d = 1'b1;
        end
      end
      XFER: begin
        if (beat_hs) begin
          first_beat_d = 1'b0;
        end
        if (pkt_done) begin
          state_d      = IDLE;
          last_grant_d = grant_idx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q      <= IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
      first_beat_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      first_beat_q <= first_beat_d;
    end
  end

`ifdef P4_ARB_PKT_CNT_EN
  logic [PKT_CNT_W-1:0] pkt_cnt_q [NUM_PORTS];
  logic [PKT_CNT_W-1:0] pkt_cnt_d [NUM_PORTS];

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_done) begin
      pkt_cnt_d[grant_idx_q] = pkt_cnt_q[grant_idx_q] + 1'b1;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt_q[i] <= '0;
      end
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_pack
    assign pkt_cnt[g*PKT_CNT_W +: PKT_CNT_W] = pkt_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_p4_ingress_arbiter.sv
// Scoreboard bench for p4_ingress_arbiter: packet-level round-robin reference
// model feeds an expected-beat queue checked by a concurrent monitor.
module tb_p4_ingress_arbiter;

  localparam int NP = 4;
  localparam int NB = 4;
  localparam int DW = NB * 8;
  localparam int MW = 9;

  typedef struct {
    logic [DW-1:0] data;
    logic [NB-1:0] keep;
    logic          last;
    logic          first;
    int            port;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*NB-1:0]  s_tkeep;
  logic [NP-1:0]     s_tvalid;
  logic [NP-1:0]     s_tlast;
  logic [NP-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic [NB-1:0]     m_tkeep;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [MW-1:0]     meta;
  logic              meta_v;

  logic [DW-1:0]     tdat [NP];
  logic [NB-1:0]     tkp  [NP];
  logic              tv   [NP];
  logic              tl   [NP];
  logic              tr   [NP];
  logic              hs_s [NP];
  logic              vld_prev [NP];

  int    n_tests;
  int    n_fail;
  int    bp_pct;
  int    gap_pct;
  int    mdl_last;
  int    mdl_cnt [NP];
  logic  last_hs;
  beat_t exp_q [$];
  beat_t src_q [NP][$];

  for (genvar g = 0; g < NP; g++) begin : g_port
    assign s_tdata[g*DW +: DW] = tdat[g];
    assign s_tkeep[g*NB +: NB] = tkp[g];
    assign s_tvalid[g]         = tv[g];
    assign s_tlast[g]          = tl[g];
    assign tr[g]               = s_tready[g];
  end

`ifdef P4_ARB_PKT_CNT_EN
  logic [NP*32-1:0] pkt_cnt;
  logic [31:0]      cnt_u [NP];
  for (genvar g = 0; g < NP; g++) begin : g_cnt
    assign cnt_u[g] = pkt_cnt[g*32 +: 32];
  end
`endif

  p4_ingress_arbiter #(
    .NUM_PORTS           (NP),
    .TDATA_NUM_BYTES     (NB),
    .USER_META_DATA_WIDTH(MW)
  ) dut (
    .s_axis_aclk            (clk),
    .s_axis_aresetn         (rst_n),
    .s_axis_tdata           (s_tdata),
    .s_axis_tkeep           (s_tkeep),
    .s_axis_tvalid          (s_tvalid),
    .s_axis_tlast           (s_tlast),
    .s_axis_tready          (s_tready),
    .m_axis_tdata           (m_tdata),
    .m_axis_tkeep           (m_tkeep),
    .m_axis_tvalid          (m_tvalid),
    .m_axis_tlast           (m_tlast),
    .m_axis_tready          (m_tready),
    .user_metadata_out      (meta),
    .user_metadata_out_valid(meta_v)
`ifdef P4_ARB_PKT_CNT_EN
    ,
    .pkt_cnt                (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({m_tvalid, m_tlast, meta_v, s_tready, m_tkeep, meta, m_tdata});
  endfunction

  function automatic bit src_pending();
    for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_counts();
`ifdef P4_ARB_PKT_CNT_EN
    for (int p = 0; p < NP; p++)
      check($sformatf("pkt_cnt%0d", p), cnt_u[p] == 32'(mdl_cnt[p]),
            64'(cnt_u[p]), 64'(mdl_cnt[p]));
`endif
  endtask

  task automatic flush_model();
    exp_q.delete();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      mdl_cnt[p] = 0;
    end
    mdl_last = NP - 1;
  endtask

  // Build packets for the ports in mask, then predict the output order: every
  // loaded port keeps requesting until drained, so each idle decision picks the
  // first port with packets left strictly after the previous winner.
  task automatic load_batch(input int unsigned mask, input int npk, input int len,
                            output int exp_cyc);
    beat_t mq [NP][$];
    beat_t be;
    int    plen, sel;
    bit    found;
    exp_cyc = 0;
    for (int p = 0; p < NP; p++) begin
      if (((mask >> p) & 1) == 0) continue;
      for (int k = 0; k < npk; k++) begin
        plen = (len > 0) ? len : int'($urandom_range(1, 6));
        exp_cyc += plen + 1;
        for (int b = 0; b < plen; b++) begin
          be.data  = $urandom;
          be.keep  = NB'($urandom);
          be.last  = (b == plen - 1);
          be.first = (b == 0);
          be.port  = p;
          src_q[p].push_back(be);
          mq[p].push_back(be);
        end
      end
    end
    do begin
      found = 1'b0;
      sel   = 0;
      for (int k = 1; k <= NP; k++) begin
        if (!found && mq[(mdl_last + k) % NP].size() != 0) begin
          found = 1'b1;
          sel   = (mdl_last + k) % NP;
        end
      end
      if (found) begin
        do begin
          be = mq[sel].pop_front();
          exp_q.push_back(be);
        end while (!be.last);
        mdl_last = sel;
        mdl_cnt[sel]++;
      end
    end while (found);
  endtask

  task automatic drain(input int exp_cyc, input bit timed);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 1'b0, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end else if (timed) begin
      check("packet_timing", cyc == exp_cyc, 64'(cyc), 64'(exp_cyc));
    end
    for (int k = 0; k < 10 && src_pending(); k++) begin
      @(negedge clk); #1;
    end
    if (src_pending()) begin
      check("source_drain_timeout", 1'b0, 64'd1, 64'd0);
      for (int p = 0; p < NP; p++) src_q[p].delete();
    end
    check_counts();
  endtask

  task automatic run_batch(input int unsigned mask, input int npk, input int len,
                           input bit timed);
    int ec;
    load_batch(mask, npk, len, ec);
    drain(ec, timed);
  endtask

  task automatic wait_exp_size(input int n);
    for (int k = 0; k < 200 && exp_q.size() != n; k++) begin
      @(negedge clk); #1;
    end
    if (exp_q.size() != n) check("wait_beat_timeout", 1'b0, 64'(exp_q.size()), 64'(n));
  endtask

  task automatic monitor();
    beat_t         e;
    logic [NP-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int p = 0; p < NP; p++) hs_s[p] = 1'b0;
        last_hs = 1'b0;
        continue;
      end
      for (int p = 0; p < NP; p++) hs_s[p] = tv[p] && tr[p];
      if (last_hs)
        check("idle_bubble", !m_tvalid && s_tready == '0,
              64'({m_tvalid, s_tready}), 64'd0);
      last_hs = 1'b0;
      if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 1'b0, 64'(m_tdata), 64'd0);
        end else begin
          e       = exp_q[0];
          exp_rdy = m_tready ? (NP'(1) << e.port) : '0;
          check("beat", m_tdata == e.data && m_tkeep == e.keep && m_tlast == e.last,
                64'({m_tlast, m_tkeep, m_tdata}), 64'({e.last, e.keep, e.data}));
          check("metadata", meta == MW'(e.port) && meta_v == e.first,
                64'({meta_v, meta}), 64'({e.first, MW'(e.port)}));
          check("s_tready", s_tready == exp_rdy, 64'(s_tready), 64'(exp_rdy));
          if (m_tready) begin
            void'(exp_q.pop_front());
            last_hs = e.last;
          end
        end
      end
    end
  endtask

  // Sources never gap a first beat and never drop valid on an unaccepted beat.
  task automatic driver();
    bit hold;
    forever begin
      @(posedge clk); #1;
      m_tready = ($urandom_range(99) >= bp_pct);
      for (int p = 0; p < NP; p++) begin
        if (rst_n && hs_s[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
        hold = vld_prev[p] && !hs_s[p];
        if (!rst_n || src_q[p].size() == 0) begin
          tv[p]   = 1'b0;
          tl[p]   = 1'b0;
          tdat[p] = '0;
          tkp[p]  = '0;
        end else begin
          tv[p]   = hold || src_q[p][0].first || ($urandom_range(99) >= gap_pct);
          tl[p]   = src_q[p][0].last;
          tdat[p] = src_q[p][0].data;
          tkp[p]  = src_q[p][0].keep;
        end
        vld_prev[p] = tv[p];
      end
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", outs() == '0, outs(), 64'd0);
    check_counts();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  initial begin
    int ec;
    n_tests  = 0;
    n_fail   = 0;
    bp_pct   = 0;
    gap_pct  = 0;
    rst_n    = 1'b0;
    m_tready = 1'b0;
    last_hs  = 1'b0;
    for (int p = 0; p < NP; p++) begin
      tv[p] = 1'b0; tl[p] = 1'b0; tdat[p] = '0; tkp[p] = '0;
      hs_s[p] = 1'b0; vld_prev[p] = 1'b0;
    end
    flush_model();
    fork
      monitor();
      driver();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs() == '0, outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check("idle_outputs", outs() == '0, outs(), 64'd0);
    end
    check_counts();

    // Single 3-beat packet from port 0, then back-to-back 1-beat packets on all ports.
    run_batch(32'h1, 1, 3, 1'b1);
    run_batch(32'hF, 3, 1, 1'b1);

    // Port 1 granted with 4-beat packets while port 2 waits; port 1 gaps mid-packet.
    gap_pct = 60;
    run_batch(32'h6, 2, 4, 1'b0);
    gap_pct = 0;

    // tready held low for 5 cycles in the middle of a 6-beat packet.
    load_batch(32'h4, 1, 6, ec);
    wait_exp_size(4);
    bp_pct = 100;
    repeat (5) @(negedge clk);
    #1;
    bp_pct = 0;
    drain(ec, 1'b0);

    for (int it = 0; it < 25; it++) begin
      bp_pct  = $urandom_range(0, 50);
      gap_pct = $urandom_range(0, 40);
      run_batch($urandom_range(1, 15), $urandom_range(1, 3), 0, 1'b0);
    end
    bp_pct  = 0;
    gap_pct = 0;

    // Leave last_grant on port 0, then reset asynchronously during beat 2 of port 1.
    run_batch(32'h1, 1, 2, 1'b1);
    load_batch(32'h2, 1, 4, ec);
    wait_exp_size(3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs() == '0, outs(), 64'd0);
    flush_model();
    repeat (3) @(posedge clk);
    check_counts();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    run_batch(32'hF, 1, 2, 1'b1);

    reset_pulse();
    run_batch(32'h8, 10, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
